// File: rtl/subtrator_pkg.sv
// ============================================================================
// Module  : subtrator_pkg
// Purpose : Shared width default and FSM state type for the serial subtractor.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package subtrator_pkg;

    localparam int c_DEFAULT_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/subtrator_completo_case.sv
// ============================================================================
// Module  : subtrator_completo_case
// Purpose : Combinational 1-bit full subtractor (A - B - Bin) as a truth table.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module subtrator_completo_case (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    always_comb begin
        D    = 1'b0;
        Bout = 1'b0;
        case ({A, B, Bin})
            3'b000: begin D = 1'b0; Bout = 1'b0; end
            3'b001: begin D = 1'b1; Bout = 1'b1; end
            3'b010: begin D = 1'b1; Bout = 1'b1; end
            3'b011: begin D = 1'b0; Bout = 1'b1; end
            3'b100: begin D = 1'b1; Bout = 1'b0; end
            3'b101: begin D = 1'b0; Bout = 1'b0; end
            3'b110: begin D = 1'b0; Bout = 1'b0; end
            3'b111: begin D = 1'b1; Bout = 1'b1; end
            default: begin D = 1'b0; Bout = 1'b0; end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/subtrator_serial.sv
// ============================================================================
// Module  : subtrator_serial
// Purpose : Bit-serial N-bit subtractor, diff = a - b - bin, LSB first.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int N = c_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         s_d,
    output logic         s_valid
);

    localparam int               c_CW   = $clog2(N + 1);
    localparam logic [c_CW-1:0]  c_LAST = c_CW'(N - 1);

    state_t            r_state;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic              r_br;
    logic [c_CW-1:0]   r_cnt;
    logic [N-1:0]      r_acc;
    logic [N-1:0]      r_diff;
    logic              r_bout;

    logic              w_d;
    logic              w_bnext;
    logic [N-1:0]      w_acc_next;

    subtrator_completo_case u_cell (
        .A    (r_a[0]),
        .B    (r_b[0]),
        .Bin  (r_br),
        .D    (w_d),
        .Bout (w_bnext)
    );

    // Result bits enter from the MSB so bit 0 lands in place after N shifts.
    if (N == 1) begin : g_acc_single
        assign w_acc_next = w_d;
    end else begin : g_acc_shift
        assign w_acc_next = {w_d, r_acc[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_bnext;
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + c_CW'(1);
                    // Published result only changes here, so diff is stable across RUN.
                    if (r_cnt == c_LAST) begin
                        r_diff  <= w_acc_next;
                        r_bout  <= w_bnext;
                        r_state <= DONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy    = (r_state == RUN);
    assign done    = (r_state == DONE);
    assign s_valid = busy;
    assign s_d     = busy & w_d;
    assign diff    = r_diff;
    assign bout    = r_bout;

endmodule

`default_nettype wire
